data_mem_arbiter: RTL

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// CPU/DMA arbiter in front of a single-port data memory: one access per two cycles, CPU priority with DMA starvation guard.
// Optional alignment checking is enabled by defining DATA_MEM_ARBITER_ALIGN_CHECK_EN.
module data_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_size,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_we,
    input  logic [2:0]  dma_size,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    output logic [31:0] mem_access_addr,
    output logic [31:0] mem_in,
    output logic        mem_write_en,
    output logic        mem_read_en,
    output logic [2:0]  mem_data_size,
    input  logic [31:0] mem_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state;
    logic        owner_dma;
    logic [3:0]  starve_cnt;
    logic [31:0] addr_q, wdata_q;
    logic        we_q;
    logic [2:0]  size_q;
    logic        misal_q;

    logic        cpu_gnt_q, dma_gnt_q, rd_en_q, wr_en_q;
    logic        cpu_rvalid_q, dma_rvalid_q, cpu_err_q, dma_err_q;
    logic [31:0] cpu_rdata_q, dma_rdata_q;

    logic        cpu_win, dma_win;
    logic [31:0] sel_addr, sel_wdata;
    logic        sel_we;
    logic [2:0]  sel_size;
    logic        sel_misal;

    always_comb begin
        dma_win   = dma_req && (!cpu_req || (starve_cnt == 4'(STARVE_LIMIT)));
        cpu_win   = cpu_req && !dma_win;
        sel_addr  = dma_win ? dma_addr  : cpu_addr;
        sel_wdata = dma_win ? dma_wdata : cpu_wdata;
        sel_we    = dma_win ? dma_we    : cpu_we;
        sel_size  = dma_win ? dma_size  : cpu_size;
    end

`ifdef DATA_MEM_ARBITER_ALIGN_CHECK_EN
    assign sel_misal = ((sel_size[1:0] == 2'b01) && sel_addr[0]) ||
                       ((sel_size == 3'b010) && (sel_addr[1:0] != 2'b00));
`else
    assign sel_misal = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner_dma    <= 1'b0;
            starve_cnt   <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            size_q       <= '0;
            misal_q      <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_err_q    <= 1'b0;
            dma_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            cpu_gnt_q    <= 1'b0;
            dma_gnt_q    <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_err_q    <= 1'b0;
            dma_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
            unique case (state)
                IDLE, RESP: begin
                    if (cpu_win || dma_win) begin
                        owner_dma <= dma_win;
                        addr_q    <= sel_addr;
                        wdata_q   <= sel_wdata;
                        we_q      <= sel_we;
                        size_q    <= sel_size;
                        misal_q   <= sel_misal;
                        cpu_gnt_q <= cpu_win;
                        dma_gnt_q <= dma_win;
                        rd_en_q   <= !sel_we && !sel_misal;
                        wr_en_q   <= sel_we && !sel_misal;
                        state     <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                    if (cpu_win && dma_req)
                        starve_cnt <= (starve_cnt == 4'hF) ? 4'hF : starve_cnt + 4'd1;
                    else
                        starve_cnt <= '0;
                end
                ISSUE: begin
                    // mem_out is combinational, so the read result is taken on the edge that ends ISSUE
                    cpu_rvalid_q <= !owner_dma;
                    dma_rvalid_q <= owner_dma;
                    cpu_err_q    <= !owner_dma && misal_q;
                    dma_err_q    <= owner_dma && misal_q;
                    cpu_rdata_q  <= (!owner_dma && !we_q && !misal_q) ? mem_out : '0;
                    dma_rdata_q  <= (owner_dma && !we_q && !misal_q) ? mem_out : '0;
                    state        <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low combinationally while reset is high, so a store caught in ISSUE never writes
    assign cpu_gnt         = cpu_gnt_q && !reset;
    assign dma_gnt         = dma_gnt_q && !reset;
    assign cpu_rvalid      = cpu_rvalid_q && !reset;
    assign dma_rvalid      = dma_rvalid_q && !reset;
    assign cpu_err         = cpu_err_q && !reset;
    assign dma_err         = dma_err_q && !reset;
    assign cpu_rdata       = reset ? '0 : cpu_rdata_q;
    assign dma_rdata       = reset ? '0 : dma_rdata_q;
    assign mem_read_en     = rd_en_q && !reset;
    assign mem_write_en    = wr_en_q && !reset;
    assign mem_access_addr = reset ? '0 : addr_q;
    assign mem_in          = reset ? '0 : wdata_q;
    assign mem_data_size   = reset ? '0 : size_q;

endmodule
